// File: rtl/mix_columns_seq.sv
// AES MixColumns, one column per clock, valid/ready in and out.
// Define MIXCOL_INV_EN to add inv_sel and InvMixColumns support.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef MIXCOL_INV_EN
  ,
  input  logic         inv_sel
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsmState;

  fsmState curSt, nextSt;

  logic [127:0] stateReg;
  logic [1:0]   colIdx;
  logic [6:0]   colBase;
  logic [31:0]  colIn;
  logic [31:0]  colOut;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // k is a 4-bit GF(2^8) constant: bit n selects b * 2^n
  function automatic logic [7:0] gmul(
    input logic [7:0] b,
    input logic [3:0] k
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mixCol(
    input logic [31:0] c,
    input logic [3:0]  k0,
    input logic [3:0]  k1,
    input logic [3:0]  k2,
    input logic [3:0]  k3
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = gmul(a0, k0) ^ gmul(a1, k1) ^ gmul(a2, k2) ^ gmul(a3, k3);
    r1 = gmul(a0, k3) ^ gmul(a1, k0) ^ gmul(a2, k1) ^ gmul(a3, k2);
    r2 = gmul(a0, k2) ^ gmul(a1, k3) ^ gmul(a2, k0) ^ gmul(a3, k1);
    r3 = gmul(a0, k1) ^ gmul(a1, k2) ^ gmul(a2, k3) ^ gmul(a3, k0);
    return {r0, r1, r2, r3};
  endfunction

  // column c lives at bits [96-32c +: 32]
  assign colBase = {~colIdx, 5'd0};
  assign colIn   = stateReg[colBase +: 32];
  assign accept  = in_valid & in_ready;

`ifdef MIXCOL_INV_EN
  logic invReg;

  always_comb begin
    colOut = mixCol(colIn, 4'h2, 4'h3, 4'h1, 4'h1);
    if (invReg)
      colOut = mixCol(colIn, 4'hE, 4'hB, 4'hD, 4'h9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      invReg <= 1'b0;
    else if (accept)
      invReg <= inv_sel;
  end
`else
  always_comb begin
    colOut = mixCol(colIn, 4'h2, 4'h3, 4'h1, 4'h1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= 128'h0;
      colIdx   <= 2'd0;
    end else if (accept) begin
      stateReg <= in_state;
      colIdx   <= 2'd0;
    end else if (curSt == CALC) begin
      stateReg[colBase +: 32] <= colOut;
      colIdx <= colIdx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      curSt <= IDLE;
    else
      curSt <= nextSt;
  end

  always_comb begin
    nextSt = curSt;
    unique case (curSt)
      IDLE: if (in_valid) nextSt = CALC;
      CALC: if (colIdx == 2'd3) nextSt = DONE;
      DONE: if (out_ready) nextSt = IDLE;
      default: nextSt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (curSt == IDLE);
    out_valid = (curSt == DONE);
    busy      = (curSt != IDLE);
    out_state = stateReg;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq; define MIXCOL_INV_EN
// to also exercise the inverse path and round trips.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic         invSel;

  int checks = 0;
  int errors = 0;

  mix_columns_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
`ifdef MIXCOL_INV_EN
    ,
    .inv_sel  (invSel)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic runTx(
    input  logic [127:0] s,
    input  logic         inv,
    input  int           hold,
    output logic [127:0] res
  );
    int n;
    bit seen;
    bit stable;
    @(negedge clk);
    in_valid = 1'b1;
    in_state = s;
    invSel   = inv;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {4{32'hA5A5_5A5A}};
    invSel   = ~inv;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = out_valid;
    end
    chk("latency", n, 4);
    res = out_state;
    if (hold > 0) begin
      in_valid = 1'b1;
      in_state = {4{32'h1234_5678}};
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (out_state !== res || !out_valid || in_ready)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      chk("hold_stable", stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_release", {out_valid, in_ready}, 2'b01);
  endtask

  logic [127:0] vecIn  [4];
  logic [127:0] vecOut [4];
  logic [127:0] r;

  initial begin
    int acc;
    int outs;
    int last;
    bit quiet;

    vecIn[0]  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    vecOut[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    vecIn[1]  = 128'hd4d4d4d5_2d26314c_d4bf5d30_00000000;
    vecOut[1] = 128'hd5d5d7d6_4d7ebdf8_046681e5_00000000;
    vecIn[2]  = 128'hc6c6c6c6_db135345_2d26314c_f20a225c;
    vecOut[2] = 128'hc6c6c6c6_8e4da1bc_4d7ebdf8_9fdc589d;
    vecIn[3]  = 128'h01010101_d4d4d4d5_db135345_d4bf5d30;
    vecOut[3] = 128'h01010101_d5d5d7d6_8e4da1bc_046681e5;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = 128'h0;
    invSel    = 1'b0;
    #12;
    chk("rst_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {in_ready, out_valid, busy}, 3'b100);

    runTx(vecIn[0], 1'b0, 0, r);
    chk("fips_vec", r, vecOut[0]);

    runTx({4{32'hd4bf5d30}}, 1'b0, 10, r);
    chk("hold_val", r, {4{32'h046681e5}});

    runTx(vecIn[1], 1'b0, 0, r);
    chk("vec_b", r, vecOut[1]);

    runTx(128'h0, 1'b0, 0, r);
    chk("zero_vec", r, 128'h0);

    // continuous in_valid: one accept every 6 cycles
    acc = 0;
    outs = 0;
    last = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (outs < 4)
          chk("thru_data", out_state, vecOut[outs]);
        else
          chk("thru_extra", outs, 3);
        outs++;
      end
      in_valid = (acc < 4);
      if (in_ready && acc < 4) begin
        in_state = vecIn[acc];
        if (acc > 0)
          chk("thru_gap", c - last, 6);
        last = c;
        acc++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("thru_accepts", acc, 4);
    chk("thru_outputs", outs, 4);

    // reset while column 2 is about to be processed
    @(negedge clk);
    in_valid = 1'b1;
    in_state = vecIn[2];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_calc", {busy, in_ready}, 2'b10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", out_state, 128'h0);
    chk("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || !in_ready)
        quiet = 1'b0;
    end
    out_ready = 1'b0;
    chk("midrst_quiet", quiet, 1);

    runTx(vecIn[3], 1'b0, 0, r);
    chk("after_rst", r, vecOut[3]);

`ifdef MIXCOL_INV_EN
    runTx(vecOut[0], 1'b1, 0, r);
    chk("inv_vec", r, vecIn[0]);
    runTx(vecOut[2], 1'b1, 3, r);
    chk("inv_vec2", r, vecIn[2]);
    for (int i = 0; i < 1000; i++) begin
      logic [127:0] s;
      logic [127:0] f;
      s = {$urandom, $urandom, $urandom, $urandom};
      runTx(s, 1'b0, 0, f);
      runTx(f, 1'b1, 0, r);
      chk("roundtrip", r, s);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
